edge_detector_multi: RTL and testbench

//  Multi-channel debounced edge detector; generalises the single-channel rising-edge filter.
//  - Per channel: synchroniser, hold-off debounce, rising/falling detection, run-time edge-mode select.
//  - Sits between raw push-button/switch pins and control FSMs that consume one-cycle event pulses.

---
 rtl/edge_detector_multi.sv | 161 ++++++++++++++++
 tb/tb_edge_detector_multi.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/edge_detector_multi.sv
// edge_detector_multi: multi-channel debounced edge detector.
// Each channel has a synchroniser, a hold-off debounce FSM, registered rising/falling
// event pulses and a run-time mode-selected pulse output.
// Optional feature: define EDGE_IRQ_EN to add sticky per-channel interrupt flags
// (irq_clr / irq_flags / irq ports). With it undefined those ports and their logic are absent.
module edge_detector_multi #(
   parameter int CHANNELS        = 4,
   parameter int DEBOUNCE_CYCLES = 130000,
   parameter int CNT_W           = 17,
   parameter int SYNC_STAGES     = 2
) (
   input  logic                clk,
   input  logic                rst,
   input  logic [CHANNELS-1:0] din,
   input  logic                enable,
   input  logic [1:0]          mode,
`ifdef EDGE_IRQ_EN
   input  logic [CHANNELS-1:0] irq_clr,
   output logic [CHANNELS-1:0] irq_flags,
   output logic                irq,
`endif
   output logic [CHANNELS-1:0] level,
   output logic [CHANNELS-1:0] rising,
   output logic [CHANNELS-1:0] falling,
   output logic [CHANNELS-1:0] pulse
);

   typedef enum logic [1:0] {
      IDLE_LOW  = 2'd0,
      HOLD_HIGH = 2'd1,
      IDLE_HIGH = 2'd2,
      HOLD_LOW  = 2'd3
   } state_e;

   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

   logic [CHANNELS-1:0] sync_q [SYNC_STAGES];
   logic [CHANNELS-1:0] sync_d [SYNC_STAGES];
   state_e              state_q [CHANNELS];
   state_e              state_d [CHANNELS];
   logic [CNT_W-1:0]    cnt_q [CHANNELS];
   logic [CNT_W-1:0]    cnt_d [CHANNELS];
   logic [CHANNELS-1:0] level_q, level_d;
   logic [CHANNELS-1:0] rising_q, rising_d;
   logic [CHANNELS-1:0] falling_q, falling_d;
   logic [CHANNELS-1:0] pulse_q, pulse_d;
   logic [CHANNELS-1:0] s;
   logic [CHANNELS-1:0] rise_evt, fall_evt;

   // Synchroniser shift, per-channel debounce FSM and event/pulse generation.
   always_comb begin
      // NOTE: every signal written here gets a default first, so no path leaves one unassigned (no latches).
      sync_d[0] = din;
      for (int k = 1; k < SYNC_STAGES; k++) begin
         sync_d[k] = sync_q[k-1];
      end
      s        = sync_q[SYNC_STAGES-1];
      level_d  = level_q;
      rise_evt = '0;
      fall_evt = '0;
      for (int i = 0; i < CHANNELS; i++) begin
         state_d[i] = state_q[i];
         cnt_d[i]   = cnt_q[i];
         case (state_q[i])
            IDLE_LOW: begin
               if (s[i]) begin
                  state_d[i] = HOLD_HIGH;
                  cnt_d[i]   = '0;
                  level_d[i] = 1'b1;
                  rise_evt[i] = 1'b1;
               end
            end
            HOLD_HIGH: begin
               // The synchronised input is ignored until the hold-off expires.
               if (cnt_q[i] == CNT_MAX) state_d[i] = IDLE_HIGH;
               else                     cnt_d[i]   = cnt_q[i] + 1'b1;
            end
            IDLE_HIGH: begin
               if (!s[i]) begin
                  state_d[i] = HOLD_LOW;
                  cnt_d[i]   = '0;
                  level_d[i] = 1'b0;
                  fall_evt[i] = 1'b1;
               end
            end
            HOLD_LOW: begin
               if (cnt_q[i] == CNT_MAX) state_d[i] = IDLE_LOW;
               else                     cnt_d[i]   = cnt_q[i] + 1'b1;
            end
            default: state_d[i] = IDLE_LOW;
         endcase
      end
      rising_d  = enable ? rise_evt : '0;
      falling_d = enable ? fall_evt : '0;
      case (mode)
         2'b00:   pulse_d = rise_evt;
         2'b01:   pulse_d = fall_evt;
         2'b10:   pulse_d = rise_evt | fall_evt;
         default: pulse_d = '0;
      endcase
      if (!enable) pulse_d = '0;
   end

   // State, counter, synchroniser and output registers with synchronous reset.
   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
      if (rst) begin
         // NOTE: the per-channel arrays are reset explicitly because a reset must abort any running hold-off.
         for (int k = 0; k < SYNC_STAGES; k++) sync_q[k] <= '0;
         for (int i = 0; i < CHANNELS; i++) begin
            state_q[i] <= IDLE_LOW;
            cnt_q[i]   <= '0;
         end
         level_q   <= '0;
         rising_q  <= '0;
         falling_q <= '0;
         pulse_q   <= '0;
      end else begin
         for (int k = 0; k < SYNC_STAGES; k++) sync_q[k] <= sync_d[k];
         for (int i = 0; i < CHANNELS; i++) begin
            state_q[i] <= state_d[i];
            cnt_q[i]   <= cnt_d[i];
         end
         level_q   <= level_d;
         rising_q  <= rising_d;
         falling_q <= falling_d;
         pulse_q   <= pulse_d;
      end
   end

   assign level   = level_q;
   assign rising  = rising_q;
   assign falling = falling_q;
   assign pulse   = pulse_q;

`ifdef EDGE_IRQ_EN
   logic [CHANNELS-1:0] irq_flags_q, irq_flags_d;
   logic                irq_q, irq_d;

   // Sticky flags: a visible pulse sets, write-1 clears, set wins; irq follows one cycle later.
   always_comb begin
      irq_flags_d = (irq_flags_q & ~irq_clr) | pulse_q;
      irq_d       = |irq_flags_q;
   end

   // Interrupt registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         irq_flags_q <= '0;
         irq_q       <= 1'b0;
      end else begin
         irq_flags_q <= irq_flags_d;
         irq_q       <= irq_d;
      end
   end

   assign irq_flags = irq_flags_q;
   assign irq       = irq_q;
`endif

endmodule

// File: tb/tb_edge_detector_multi.sv
// Testbench for edge_detector_multi (CHANNELS=4, DEBOUNCE_CYCLES=8, SYNC_STAGES=2).
// Directed scenarios with literal expectations, then randomized stimulus compared every
// cycle against a behavioural model. Define EDGE_IRQ_EN to also cover the interrupt flags.
module tb_edge_detector_multi;
   localparam int CH = 4;
   localparam int DB = 8;
   localparam int CW = 4;
   localparam int SS = 2;

   logic          clk = 1'b0;
   logic          rst;
   logic          enable;
   logic [1:0]    mode;
   logic [CH-1:0] din;
   logic [CH-1:0] level, rising, falling, pulse;
`ifdef EDGE_IRQ_EN
   logic [CH-1:0] irq_clr;
   logic [CH-1:0] irq_flags;
   logic          irq;
`endif

   always #5 clk = ~clk;

   edge_detector_multi #(
      .CHANNELS(CH), .DEBOUNCE_CYCLES(DB), .CNT_W(CW), .SYNC_STAGES(SS)
   ) dut (
      .clk(clk), .rst(rst), .din(din), .enable(enable), .mode(mode),
`ifdef EDGE_IRQ_EN
      .irq_clr(irq_clr), .irq_flags(irq_flags), .irq(irq),
`endif
      .level(level), .rising(rising), .falling(falling), .pulse(pulse)
   );

   int n_cmp  = 0;
   int n_fail = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- behavioural model ----------------
   // An edge is accepted when the synchronised input differs from the debounced level
   // and at least DB+1 clocks have passed since the previous accepted edge on that channel.
   logic [CH-1:0] m_hist [SS];
   logic [CH-1:0] m_level, m_rise, m_fall, m_pulse;
   logic [CH-1:0] m_flags;
   logic          m_irq;
   int            m_age [CH];
   bit            m_valid = 1'b0;

   always @(posedge clk) begin
      logic [CH-1:0] sv, r, f;
      if (rst) begin
         for (int k = 0; k < SS; k++) m_hist[k] = '0;
         for (int i = 0; i < CH; i++) m_age[i] = DB + 1;
         m_level = '0; m_rise = '0; m_fall = '0; m_pulse = '0;
         m_flags = '0; m_irq = 1'b0;
         m_valid = 1'b1;
      end else begin
         sv = m_hist[SS-1];
         for (int k = SS-1; k > 0; k--) m_hist[k] = m_hist[k-1];
         m_hist[0] = din;
`ifdef EDGE_IRQ_EN
         m_irq   = |m_flags;
         m_flags = (m_flags & ~irq_clr) | m_pulse;
`endif
         r = '0; f = '0;
         for (int i = 0; i < CH; i++) begin
            if (m_age[i] <= DB) m_age[i]++;
            if (sv[i] != m_level[i] && m_age[i] > DB) begin
               m_level[i] = sv[i];
               m_age[i]   = 0;
               if (sv[i]) r[i] = 1'b1;
               else       f[i] = 1'b1;
            end
         end
         m_rise  = enable ? r : '0;
         m_fall  = enable ? f : '0;
         m_pulse = !enable    ? '0 :
                   mode == 0  ? r :
                   mode == 1  ? f :
                   mode == 2  ? (r | f) : '0;
      end
   end

   // Single compare process: DUT outputs against the model every cycle after the first reset.
   always @(negedge clk) begin
      if (m_valid) begin
         check("level",   32'(level),   32'(m_level));
         check("rising",  32'(rising),  32'(m_rise));
         check("falling", 32'(falling), 32'(m_fall));
         check("pulse",   32'(pulse),   32'(m_pulse));
`ifdef EDGE_IRQ_EN
         check("irq_flags", 32'(irq_flags), 32'(m_flags));
         check("irq",       32'(irq),       32'(m_irq));
`endif
      end
   end

   // ---------------- stimulus helpers ----------------
   int cnt_rise [CH];
   int cnt_fall [CH];
   int cnt_pulse [CH];

   task automatic clear_counts();
      for (int i = 0; i < CH; i++) begin
         cnt_rise[i] = 0; cnt_fall[i] = 0; cnt_pulse[i] = 0;
      end
   endtask

   // Advance n cycles; inputs change right after a falling edge, outputs are tallied there.
   task automatic tick(input int n);
      repeat (n) begin
         @(negedge clk);
         for (int i = 0; i < CH; i++) begin
            if (rising[i])  cnt_rise[i]++;
            if (falling[i]) cnt_fall[i]++;
            if (pulse[i])   cnt_pulse[i]++;
         end
      end
   endtask

   initial begin
      #2_000_000;
      $display("FAIL timeout: simulation did not finish, got running expected finished");
      $fatal(1, "timeout");
   end

   initial begin
      int exp_pulse [3];
      logic [1:0] modes [3];
      rst = 1'b1; din = '0; enable = 1'b1; mode = 2'b00;
`ifdef EDGE_IRQ_EN
      irq_clr = '0;
`endif
      clear_counts();

      // Reset: three cycles with rst high, everything low.
      tick(3);
      check("reset_level",   32'(level),   0);
      check("reset_rising",  32'(rising),  0);
      check("reset_falling", 32'(falling), 0);
      check("reset_pulse",   32'(pulse),   0);
      rst = 1'b0;

      // Latency: din[0] rises, pulse appears on the third cycle, lasting one cycle.
      din[0] = 1'b1;
      tick(1); check("lat_c1_rising", 32'(rising), 0);
      tick(1); check("lat_c2_rising", 32'(rising), 0);
      tick(1);
      check("lat_c3_rising", 32'(rising), 32'h1);
      check("lat_c3_pulse",  32'(pulse),  32'h1);
      check("lat_c3_level",  32'(level),  32'h1);
      tick(1); check("lat_c4_rising", 32'(rising), 0);
      tick(20);

      // Bounce on ch1: alternate each cycle, then hold high.
      clear_counts();
      for (int j = 0; j < 6; j++) begin
         din[1] = j[0];
         tick(1);
      end
      din[1] = 1'b1;
      tick(20);
      check("bounce_rise_count", 32'(cnt_rise[1]), 1);
      check("bounce_fall_count", 32'(cnt_fall[1]), 0);
      check("bounce_level",      32'(level[1]),    1);

      // Mode select on ch2: one rising and one falling edge per mode.
      modes[0] = 2'b01; modes[1] = 2'b10; modes[2] = 2'b11;
      exp_pulse[0] = 1; exp_pulse[1] = 2; exp_pulse[2] = 0;
      for (int m = 0; m < 3; m++) begin
         clear_counts();
         mode = modes[m];
         din[2] = 1'b1; tick(20);
         din[2] = 1'b0; tick(20);
         check("mode_pulse_count", 32'(cnt_pulse[2]), 32'(exp_pulse[m]));
         check("mode_rise_count",  32'(cnt_rise[2]),  1);
         check("mode_fall_count",  32'(cnt_fall[2]),  1);
      end
      mode = 2'b00;

      // Concurrency: all channels rise in the same cycle.
      din = '0; tick(20);
      din = 4'hF; tick(3);
      check("conc_rising", 32'(rising), 32'hF);
      check("conc_pulse",  32'(pulse),  32'hF);
      tick(20);
      din = '0; tick(20);

      // Enable low: edges lost, level still tracks.
      enable = 1'b0;
      clear_counts();
      din = 4'hF; tick(20);
      check("dis_rise_count",  32'(cnt_rise[0] + cnt_rise[1] + cnt_rise[2] + cnt_rise[3]), 0);
      check("dis_pulse_count", 32'(cnt_pulse[0] + cnt_pulse[1] + cnt_pulse[2] + cnt_pulse[3]), 0);
      check("dis_level",       32'(level), 32'hF);
      enable = 1'b1;
      din = '0; tick(20);

      // Reset during a hold on ch3, din[3] kept high.
      din[3] = 1'b1; tick(3);
      check("midhold_first_rise", 32'(rising), 32'h8);
      tick(3);
      rst = 1'b1; tick(1); rst = 1'b0;
      check("midhold_level",  32'(level),  0);
      check("midhold_rising", 32'(rising), 0);
      check("midhold_pulse",  32'(pulse),  0);
      tick(1); check("rel_c1_rising", 32'(rising), 0);
      tick(1); check("rel_c2_rising", 32'(rising), 0);
      tick(1);
      check("rel_c3_rising", 32'(rising), 32'h8);
      check("rel_c3_level",  32'(level),  32'h8);
      tick(20);

`ifdef EDGE_IRQ_EN
      // Flag set by a pulse, irq one cycle later; clear coinciding with a pulse keeps the flag.
      din[0] = 1'b1; tick(3);
      check("irq_pulse", 32'(pulse), 32'h1);
      tick(1); check("irq_flags_set", 32'(irq_flags), 32'h1);
      tick(1); check("irq_out", 32'(irq), 1);
      din[0] = 1'b0; tick(20);
      din[0] = 1'b1; tick(3);
      check("irq_pulse2", 32'(pulse), 32'h1);
      irq_clr = 4'h1; tick(1); irq_clr = '0;
      check("irq_set_wins", 32'(irq_flags), 32'h1);
      irq_clr = 4'h1; tick(1); irq_clr = '0;
      check("irq_cleared", 32'(irq_flags), 0);
      tick(5);
`endif

      // Randomized phase, checked every cycle by the compare process.
      for (int c = 0; c < 3000; c++) begin
         for (int i = 0; i < CH; i++) begin
            if ($urandom_range(0, 9) == 0) din[i] = ~din[i];
         end
         enable = ($urandom_range(0, 7) != 0);
         if ($urandom_range(0, 19) == 0) mode = 2'($urandom_range(0, 3));
         rst = ($urandom_range(0, 299) == 0);
`ifdef EDGE_IRQ_EN
         irq_clr = ($urandom_range(0, 3) == 0) ? CH'($urandom) : '0;
`endif
         tick(1);
      end
      rst = 1'b0;
      tick(5);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
